// File: rtl/ai_dense_mac.sv
// ai_dense_mac: dense-layer compute engine for one layer.
// For each output neuron j it reads one 4-bit signed bias and N_IN
// weight/activation pairs through 1-cycle-latency read ports. It accumulates
// bias + sum(w*act) in a wrapping ACC_BITS signed accumulator, then applies
// the output shift and clamp, and hands the result out over valid/ready.
// Optional macro AI_DENSE_RELU_EN: when defined, the output uses an unsigned
// ReLU clamp to [0, 2^A_BITS-1]. Otherwise it uses signed two's-complement
// saturation to A_BITS.
module ai_dense_mac #(
    parameter int N_IN      = 32,
    parameter int N_OUT     = 16,
    parameter int A_BITS    = 8,
    parameter int ACC_BITS  = 18,
    parameter int OUT_SHIFT = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(N_OUT)-1:0]         b_addr,
    input  logic signed [3:0]                b_data,
    output logic [$clog2(N_IN*N_OUT)-1:0]    w_addr,
    input  logic signed [3:0]                w_data,
    output logic [$clog2(N_IN)-1:0]          act_addr,
    input  logic [A_BITS-1:0]                act_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [A_BITS-1:0]                out_data,
    output logic [$clog2(N_OUT)-1:0]         out_idx
);

    localparam int JW = $clog2(N_OUT);
    localparam int KW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN*N_OUT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] BIAS  = 3'd1;
    localparam logic [2:0] MAC   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] EMIT  = 3'd4;

`ifdef AI_DENSE_RELU_EN
    localparam logic signed [ACC_BITS-1:0] UMAX = ACC_BITS'((2**A_BITS) - 1);
`else
    localparam logic signed [ACC_BITS-1:0] SMAX = ACC_BITS'((2**(A_BITS-1)) - 1);
    localparam logic signed [ACC_BITS-1:0] SMIN = ACC_BITS'(-(2**(A_BITS-1)));
`endif

    logic [2:0]                  state;
    logic [JW-1:0]               j;
    logic [KW-1:0]               k;
    logic signed [ACC_BITS-1:0]  acc;
    logic signed [A_BITS:0]      act_s;
    logic signed [A_BITS+4:0]    prod;
    logic signed [ACC_BITS-1:0]  acc_sum;

    // Shift the accumulator, then clamp it to the A_BITS output format.
    function automatic logic [A_BITS-1:0] clamp_out(input logic signed [ACC_BITS-1:0] a);
        logic signed [ACC_BITS-1:0] r;
        r = a >>> OUT_SHIFT;
`ifdef AI_DENSE_RELU_EN
        if (r[ACC_BITS-1])
            clamp_out = '0;
        else if (r > UMAX)
            clamp_out = '1;
        else
            clamp_out = r[A_BITS-1:0];
`else
        if (r < SMIN)
            clamp_out = {1'b1, {(A_BITS-1){1'b0}}};
        else if (r > SMAX)
            clamp_out = {1'b0, {(A_BITS-1){1'b1}}};
        else
            clamp_out = r[A_BITS-1:0];
`endif
    endfunction

    // The weight is sign-extended and the activation zero-extended, so the
    // product is a plain signed multiply. The sum wraps at ACC_BITS.
    assign act_s   = {1'b0, act_data};
    assign prod    = w_data * act_s;
    assign acc_sum = acc + ACC_BITS'(prod);

    // Layer sequencer: address generation, accumulation and the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            b_addr    <= '0;
            w_addr    <= '0;
            act_addr  <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            acc       <= '0;
            j         <= '0;
            k         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= BIAS;
                        busy   <= 1'b1;
                        j      <= '0;
                        b_addr <= '0;
                    end
                end
                BIAS: begin
                    state    <= MAC;
                    k        <= '0;
                    w_addr   <= WW'(int'(j) * N_IN);
                    act_addr <= '0;
                end
                MAC: begin
                    // Read data lags the address by one cycle. At k=0 the bias
                    // arrives; after that, the product issued at k-1 arrives.
                    if (k == '0)
                        acc <= ACC_BITS'(b_data);
                    else
                        acc <= acc_sum;
                    if (k == KW'(N_IN - 1)) begin
                        state <= DRAIN;
                    end else begin
                        k        <= k + KW'(1);
                        w_addr   <= w_addr + WW'(1);
                        act_addr <= act_addr + KW'(1);
                    end
                end
                DRAIN: begin
                    // The last product lands here. The result is registered
                    // directly from the final sum, so EMIT presents it at once.
                    acc       <= acc_sum;
                    out_data  <= clamp_out(acc_sum);
                    out_idx   <= j;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (j == JW'(N_OUT - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            j      <= j + JW'(1);
                            b_addr <= j + JW'(1);
                            state  <= BIAS;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ai_dense_mac.sv
// tb_ai_dense_mac: directed bench for ai_dense_mac (N_IN=4, N_OUT=2).
// Two instances share the stimulus and memories: one with OUT_SHIFT=0 and
// one with OUT_SHIFT=5. A behavioural model computes every neuron result
// from the memory contents, and literal values pin the model.
module tb_ai_dense_mac;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 2;
    localparam int A_BITS = 8;
    localparam int ACC_B  = 18;
    localparam int SH_B   = 5;

`ifdef AI_DENSE_RELU_EN
    localparam int T3_A = 0,   T3_B = 0;
    localparam int T4_A = 255, T4_B = 223;
    localparam int T5_A1 = 195;
`else
    localparam int T3_A = 128, T3_B = 128;
    localparam int T4_A = 127, T4_B = 127;
    localparam int T5_A1 = 127;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    logic signed [3:0] bmem [N_OUT];
    logic signed [3:0] wmem [N_IN*N_OUT];
    logic [7:0]        amem [N_IN];

    logic busy_a, done_a, out_valid_a, busy_b, done_b, out_valid_b;
    logic [0:0] b_addr_a, b_addr_b, out_idx_a, out_idx_b;
    logic [2:0] w_addr_a, w_addr_b;
    logic [1:0] act_addr_a, act_addr_b;
    logic [7:0] out_data_a, out_data_b, ad_a, ad_b;
    logic signed [3:0] bd_a, bd_b, wd_a, wd_b;

    int n_cmp = 0;
    int n_bad = 0;

    ai_dense_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .A_BITS(A_BITS), .ACC_BITS(ACC_B), .OUT_SHIFT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a),
        .b_addr(b_addr_a), .b_data(bd_a), .w_addr(w_addr_a), .w_data(wd_a),
        .act_addr(act_addr_a), .act_data(ad_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_idx(out_idx_a)
    );

    ai_dense_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .A_BITS(A_BITS), .ACC_BITS(ACC_B), .OUT_SHIFT(SH_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b),
        .b_addr(b_addr_b), .b_data(bd_b), .w_addr(w_addr_b), .w_data(wd_b),
        .act_addr(act_addr_b), .act_data(ad_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_idx(out_idx_b)
    );

    // Synchronous read memories with one cycle of latency.
    always @(posedge clk) begin
        bd_a <= bmem[b_addr_a];
        wd_a <= wmem[w_addr_a];
        ad_a <= amem[act_addr_a];
        bd_b <= bmem[b_addr_b];
        wd_b <= wmem[w_addr_b];
        ad_b <= amem[act_addr_b];
    end

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Result of neuron j: bias plus the dot product, wrapped to the
    // accumulator width, shifted, then clamped to the output format.
    function automatic int model_out(input int j, input int shift);
        int acc;
        int r;
        acc = int'(bmem[j]);
        for (int i = 0; i < N_IN; i++)
            acc += int'(wmem[j*N_IN+i]) * int'(amem[i]);
        acc = (acc <<< (32 - ACC_B)) >>> (32 - ACC_B);
        r = acc >>> shift;
`ifdef AI_DENSE_RELU_EN
        if (r < 0) r = 0;
        if (r > (1 << A_BITS) - 1) r = (1 << A_BITS) - 1;
        return r;
`else
        if (r < -(1 << (A_BITS-1))) r = -(1 << (A_BITS-1));
        if (r > (1 << (A_BITS-1)) - 1) r = (1 << (A_BITS-1)) - 1;
        return r & ((1 << A_BITS) - 1);
`endif
    endfunction

    // Check every presented result against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_a) check("model_a", int'(out_data_a), model_out(int'(out_idx_a), 0));
            if (out_valid_b) check("model_b", int'(out_data_b), model_out(int'(out_idx_b), SH_B));
        end
    end

    task automatic set_mem(input int b0, input int b1, input int w0, input int w1,
                           input int a0, input int a1, input int a2, input int a3);
        bmem[0] = 4'(b0);
        bmem[1] = 4'(b1);
        for (int i = 0; i < N_IN; i++) begin
            wmem[i]      = 4'(w0);
            wmem[N_IN+i] = 4'(w1);
        end
        amem[0] = 8'(a0);
        amem[1] = 8'(a1);
        amem[2] = 8'(a2);
        amem[3] = 8'(a3);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid_a && cyc < 40);
    endtask

    // Full layer with out_ready high. The first latency and the per-neuron
    // spacing are both N_IN+3, and done pulses exactly once.
    task automatic run_layer(input string tag, input bit poke,
                             input int ea0, input int ea1, input int eb0, input int eb1);
        int cyc;
        int extra;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 3);
            if (cyc == 1) check({tag, "_busy"}, int'(busy_a), 1);
        end while (!out_valid_a && cyc < 40);
        start = 1'b0;
        check({tag, "_lat"}, cyc, N_IN + 3);
        check({tag, "_idx0"}, int'(out_idx_a), 0);
        check({tag, "_a0"}, int'(out_data_a), ea0);
        check({tag, "_b0"}, int'(out_data_b), eb0);
        wait_valid(cyc);
        check({tag, "_gap"}, cyc, N_IN + 3);
        check({tag, "_idx1"}, int'(out_idx_a), 1);
        check({tag, "_a1"}, int'(out_data_a), ea1);
        check({tag, "_b1"}, int'(out_data_b), eb1);
        @(negedge clk);
        check({tag, "_done"}, int'(done_a), 1);
        check({tag, "_busy_end"}, int'(busy_a), 0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        check({tag, "_done_once"}, extra, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_done"}, int'(done_a), 0);
        check({tag, "_valid"}, int'(out_valid_a), 0);
        check({tag, "_baddr"}, int'(b_addr_a), 0);
        check({tag, "_waddr"}, int'(w_addr_a), 0);
        check({tag, "_aaddr"}, int'(act_addr_a), 0);
        check({tag, "_data"}, int'(out_data_a), 0);
        check({tag, "_idx"}, int'(out_idx_a), 0);
        check({tag, "_busy_b"}, int'(busy_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        set_mem(3, 3, 1, 1, 10, 20, 30, 40);

        // Reset held for three cycles, with a start pulse inside it.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_start_ignored", int'(busy_a), 0);
        check("rst_no_valid", int'(out_valid_a), 0);

        // Unit weights with bias 3: 3+10+20+30+40 = 103; 103>>>5 = 3.
        run_layer("t2", 1'b0, 103, 103, 3, 3);

        // Weights -8, acts 255, bias -8: acc = -8168.
        set_mem(-8, -8, -8, -8, 255, 255, 255, 255);
        run_layer("t3", 1'b0, T3_A, T3_A, T3_B, T3_B);

        // Weights 7, acts 255, bias 7: acc = 7147; 7147>>>5 = 223.
        set_mem(7, 7, 7, 7, 255, 255, 255, 255);
        run_layer("t4", 1'b0, T4_A, T4_A, T4_B, T4_B);

        // Backpressure on neuron 0. Neuron 1 = -5 + 2*100 = 195.
        set_mem(3, -5, 1, 2, 10, 20, 30, 40);
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!out_valid_a && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_lat", cyc, N_IN + 3);
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_valid", int'(out_valid_a), 1);
            check("t5_hold_data", int'(out_data_a), 103);
            check("t5_hold_data_b", int'(out_data_b), 3);
            check("t5_hold_idx", int'(out_idx_a), 0);
            check("t5_hold_waddr", int'(w_addr_a), 3);
            check("t5_hold_baddr", int'(b_addr_a), 0);
        end
        out_ready = 1'b1;
        wait_valid(cyc);
        check("t5_gap", cyc, N_IN + 3);
        check("t5_idx1", int'(out_idx_a), 1);
        check("t5_a1", int'(out_data_a), T5_A1);
        check("t5_b1", int'(out_data_b), 6);
        @(negedge clk);
        check("t5_done", int'(done_a), 1);
        check("t5_busy_end", int'(busy_a), 0);

        // Abort during the MAC of neuron 1, then a clean rerun with a stray start.
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!out_valid_a && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_lat", cyc, N_IN + 3);
        repeat (3) @(negedge clk);
        check("t6_mac_waddr", int'(w_addr_a), 5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_idle_busy", int'(busy_a), 0);
        check("t6_idle_valid", int'(out_valid_a), 0);
        run_layer("t6", 1'b1, 103, T5_A1, 3, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
